// File: rtl/pf_fetch_pkg.sv
// Shared playfield constants and the tile addressing helpers used by the fetcher.
package pf_fetch_pkg;

  localparam int unsigned PF_COLS    = 32;
  localparam int unsigned PF_ROWS    = 30;
  localparam int unsigned PF_VIS_W   = 256;
  localparam int unsigned PF_VIS_H   = 240;
  localparam int unsigned PF_LATENCY = 8;

  typedef logic [2:0] pf_phase_t;

  // Flip mirrors both axes; the row mirror is about the 30-row visible map.
  function automatic logic [9:0] pf_tile_index(logic [8:0] h, logic [8:0] v, logic f);
    logic [4:0] col;
    logic [4:0] row;
    col = f ? 5'(PF_COLS - 1) - h[7:3] : h[7:3];
    row = f ? 5'(PF_ROWS - 1) - v[7:3] : v[7:3];
    return {row, col};
  endfunction

  function automatic logic [2:0] pf_line(logic [8:0] v, logic f);
    return f ? 3'd7 - v[2:0] : v[2:0];
  endfunction

endpackage

// File: rtl/pf_fetch_if.sv
// Playfield RAM port-B and picture ROM bus between the fetcher and the memories.
interface pf_fetch_if;
  logic [7:0]  pf_addr_b;
  logic [3:0]  pf_ce_b;
  logic [31:0] pf_dout_b;
  logic [10:0] pf_rom_addr;
  logic [7:0]  pf_rom_lo;
  logic [7:0]  pf_rom_hi;

  modport master (
    output pf_addr_b,
    output pf_ce_b,
    output pf_rom_addr,
    input  pf_dout_b,
    input  pf_rom_lo,
    input  pf_rom_hi
  );

  modport slave (
    input  pf_addr_b,
    input  pf_ce_b,
    input  pf_rom_addr,
    output pf_dout_b,
    output pf_rom_lo,
    output pf_rom_hi
  );
endinterface

// File: rtl/pf_shift.sv
// Two-plane 8-bit pixel shifter; direction is captured with each load so a tile
// already on screen finishes in the order it was loaded with.
module pf_shift (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       lsb_first_i,
  input  logic [7:0] lo_i,
  input  logic [7:0] hi_i,
  output logic [1:0] pix_o
);

  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       lsb_q, lsb_d;

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    lsb_d = lsb_q;
    if (load_i) begin
      lo_d  = lo_i;
      hi_d  = hi_i;
      lsb_d = lsb_first_i;
    end else if (lsb_q) begin
      lo_d = {1'b0, lo_q[7:1]};
      hi_d = {1'b0, hi_q[7:1]};
    end else begin
      lo_d = {lo_q[6:0], 1'b0};
      hi_d = {hi_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lo_q  <= 8'h00;
      hi_q  <= 8'h00;
      lsb_q <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      lsb_q <= lsb_d;
    end
  end

  assign pix_o = lsb_q ? {hi_q[0], lo_q[0]} : {hi_q[7], lo_q[7]};

endmodule

// File: rtl/pf_fetch.sv
// Playfield tile fetcher: an 8-phase pipeline per tile (RAM code, ROM planes,
// shifter load) producing one 2-bit pixel per clock, 8 clocks behind hcount.
module pf_fetch
  import pf_fetch_pkg::*;
(
  input  logic       clk_12mhz,
  input  logic       reset,
  input  logic [8:0] hcount,
  input  logic [8:0] vcount,
  input  logic       flip,
  pf_fetch_if.master bus,
  output logic [1:0] pf_pix,
  output logic       pf_valid
);

  logic [7:0]  addr_q, addr_d;
  logic [3:0]  ce_q, ce_d;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic [1:0]  bank_q, bank_d;
  logic [7:0]  code_q, code_d;
  logic        flip_q, flip_d;
  logic [7:0]  lo_hold_q, lo_hold_d;
  logic [7:0]  hi_hold_q, hi_hold_d;
  logic        valid_q, valid_d;

  logic        in_win;
  pf_phase_t   phase;
  logic [9:0]  tile_idx;
  logic [9:0]  h_next;
  logic        load;
  logic [1:0]  shift_pix;

  assign in_win   = (32'(hcount) < PF_VIS_W) && (32'(vcount) < PF_VIS_H);
  assign phase    = hcount[2:0];
  assign tile_idx = pf_tile_index(hcount, vcount, flip);
  assign load     = in_win && (phase == 3'd7);
  assign h_next   = {1'b0, hcount} + 10'd1;

  always_comb begin
    addr_d     = addr_q;
    ce_d       = 4'b1111;
    rom_addr_d = rom_addr_q;
    bank_d     = bank_q;
    code_d     = code_q;
    flip_d     = flip_q;
    lo_hold_d  = lo_hold_q;
    hi_hold_d  = hi_hold_q;
    if (in_win) begin
      case (phase)
        3'd0: begin
          addr_d = tile_idx[7:0];
          ce_d   = 4'b0000;
          bank_d = tile_idx[9:8];
          flip_d = flip;
        end
        3'd1: code_d = bus.pf_dout_b[{bank_q, 3'b000} +: 8];
        3'd2: rom_addr_d = {code_q, pf_line(vcount, flip_q)};
        3'd3: begin
          lo_hold_d = bus.pf_rom_lo;
          hi_hold_d = bus.pf_rom_hi;
        end
        default: ;
      endcase
    end
  end

  // Registered one clock ahead from hcount+1, so hcount must advance by one per clock.
  assign valid_d = (32'(vcount) < PF_VIS_H) && (h_next >= 10'(PF_LATENCY))
                   && (h_next < 10'(PF_VIS_W + PF_LATENCY));

  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      addr_q     <= 8'h00;
      ce_q       <= 4'b1111;
      rom_addr_q <= 11'h000;
      bank_q     <= 2'b00;
      code_q     <= 8'h00;
      flip_q     <= 1'b0;
      lo_hold_q  <= 8'h00;
      hi_hold_q  <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      ce_q       <= ce_d;
      rom_addr_q <= rom_addr_d;
      bank_q     <= bank_d;
      code_q     <= code_d;
      flip_q     <= flip_d;
      lo_hold_q  <= lo_hold_d;
      hi_hold_q  <= hi_hold_d;
      valid_q    <= valid_d;
    end
  end

  pf_shift u_shift (
    .clk_i       (clk_12mhz),
    .rst_i       (reset),
    .load_i      (load),
    .lsb_first_i (flip_q),
    .lo_i        (lo_hold_q),
    .hi_i        (hi_hold_q),
    .pix_o       (shift_pix)
  );

  assign bus.pf_addr_b   = addr_q;
  assign bus.pf_ce_b     = ce_q;
  assign bus.pf_rom_addr = rom_addr_q;
  assign pf_valid        = valid_q;
  assign pf_pix          = valid_q ? shift_pix : 2'b00;

endmodule

// File: tb/tb_pf_fetch.sv
// Randomized line-by-line bench for pf_fetch against a screen-pixel reference model.
module tb_pf_fetch;
  import pf_fetch_pkg::*;

  logic       clk_12mhz = 1'b0;
  logic       reset;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       flip;
  logic [1:0] pf_pix;
  logic       pf_valid;

  pf_fetch_if bus ();

  pf_fetch dut (
    .clk_12mhz (clk_12mhz),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .flip      (flip),
    .bus       (bus),
    .pf_pix    (pf_pix),
    .pf_valid  (pf_valid)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  logic [7:0] ram_m    [4][256];
  logic [7:0] rom_lo_m [2048];
  logic [7:0] rom_hi_m [2048];

  // A disabled bank drives zero, so a wrong enable corrupts the fetched code.
  assign bus.pf_dout_b[7:0]   = bus.pf_ce_b[0] ? 8'h00 : ram_m[0][bus.pf_addr_b];
  assign bus.pf_dout_b[15:8]  = bus.pf_ce_b[1] ? 8'h00 : ram_m[1][bus.pf_addr_b];
  assign bus.pf_dout_b[23:16] = bus.pf_ce_b[2] ? 8'h00 : ram_m[2][bus.pf_addr_b];
  assign bus.pf_dout_b[31:24] = bus.pf_ce_b[3] ? 8'h00 : ram_m[3][bus.pf_addr_b];
  assign bus.pf_rom_lo = rom_lo_m[bus.pf_rom_addr];
  assign bus.pf_rom_hi = rom_hi_m[bus.pf_rom_addr];

  int checks = 0;
  int errors = 0;

  logic [1:0]  obs_pix  [320];
  logic [7:0]  obs_addr [320];
  logic [3:0]  obs_ce   [320];
  logic [10:0] obs_rom  [320];
  bit          tile_flip [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Screen pixel x of line y as seen with flip f, straight from the tile rules.
  function automatic logic [1:0] model_pix(input int x, input int y, input bit f);
    int col, row, line, b, idx, a;
    logic [7:0] code;
    col  = x / 8;
    row  = y / 8;
    line = y % 8;
    b    = 7 - x % 8;
    if (f) begin
      col  = 31 - col;
      row  = 29 - row;
      line = 7 - line;
      b    = x % 8;
    end
    idx  = row * 32 + col;
    code = ram_m[idx / 256][idx % 256];
    a    = int'(code) * 8 + line;
    return {rom_hi_m[a][b], rom_lo_m[a][b]};
  endfunction

  // flip_mode: 0/1 constant, 2 random toggles. rst_h >= 0 pulses reset during that hcount.
  task automatic run_line(input int v, input int flip_mode, input int rst_h);
    int  h0;
    bit  vis;
    logic [1:0] exp_pix;
    logic [3:0] exp_ce;
    h0 = -1;
    if (flip_mode < 2) flip = flip_mode[0];
    for (int h = 0; h < 320; h++) begin
      hcount = 9'(h);
      vcount = 9'(v);
      reset  = (h == rst_h);
      if (flip_mode == 2 && $urandom_range(0, 15) == 0) flip = ~flip;
      if (h < 256 && h % 8 == 0) tile_flip[h / 8] = flip;
      if (rst_h >= 0 && h > rst_h && h % 8 == 0 && h0 < 0) h0 = h;
      @(negedge clk_12mhz);
      obs_pix[h]  = pf_pix;
      obs_addr[h] = bus.pf_addr_b;
      obs_ce[h]   = bus.pf_ce_b;
      obs_rom[h]  = bus.pf_rom_addr;
      vis = (v < 240) && (h >= 8) && (h <= 263);
      if (!(rst_h >= 0 && h == rst_h + 1)) check_eq("valid", 32'(pf_valid), 32'(vis));
      exp_pix = 2'b00;
      if (vis) exp_pix = model_pix(h - 8, v, tile_flip[(h - 8) / 8]);
      if (rst_h >= 0 && h > rst_h && (h0 < 0 || h < h0 + 8)) exp_pix = 2'b00;
      check_eq("pix", 32'(pf_pix), 32'(exp_pix));
      exp_ce = (h >= 1 && v < 240 && h - 1 < 256 && (h - 1) % 8 == 0 && h - 1 != rst_h)
               ? 4'b0000 : 4'b1111;
      check_eq("ce_b", 32'(bus.pf_ce_b), 32'(exp_ce));
      @(posedge clk_12mhz);
      #1;
    end
    reset = 1'b0;
  endtask

  int seq_a [8] = '{3, 0, 0, 0, 0, 0, 0, 1};
  int seq_b [8] = '{1, 0, 0, 0, 0, 0, 0, 3};

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) ram_m[b][a] = 8'($urandom);
    for (int a = 0; a < 2048; a++) begin
      rom_lo_m[a] = 8'($urandom);
      rom_hi_m[a] = 8'($urandom);
    end
    reset  = 1'b1;
    hcount = 9'd0;
    vcount = 9'd0;
    flip   = 1'b0;
    repeat (3) @(posedge clk_12mhz);
    @(negedge clk_12mhz);
    check_eq("rst_pix", 32'(pf_pix), 32'd0);
    check_eq("rst_valid", 32'(pf_valid), 32'd0);
    check_eq("rst_ce_b", 32'(bus.pf_ce_b), 32'hF);
    check_eq("rst_addr_b", 32'(bus.pf_addr_b), 32'd0);
    check_eq("rst_rom_addr", 32'(bus.pf_rom_addr), 32'd0);
    @(posedge clk_12mhz);
    #1;
    reset = 1'b0;

    // Bank select: row 17 col 5 -> index 0x225, bank 2 address 0x25.
    ram_m[0][8'h25] = 8'h11;
    ram_m[1][8'h25] = 8'h22;
    ram_m[2][8'h25] = 8'h5A;
    ram_m[3][8'h25] = 8'h33;
    run_line(137, 0, -1);
    check_eq("bank_addr_b", 32'(obs_addr[41]), 32'h25);
    check_eq("bank_ce_b", 32'(obs_ce[41]), 32'h0);
    check_eq("bank_ce_off", 32'(obs_ce[42]), 32'hF);
    check_eq("bank_rom_addr", 32'(obs_rom[43]), 32'h2D1);

    // Pixel order for tile (0,0), line 3, unflipped and flipped.
    ram_m[0][8'h00] = 8'h10;
    rom_lo_m[8'h10 * 8 + 3] = 8'h81;
    rom_hi_m[8'h10 * 8 + 3] = 8'h80;
    run_line(3, 0, -1);
    for (int i = 0; i < 8; i++) check_eq("order", 32'(obs_pix[8 + i]), 32'(seq_a[i]));
    run_line(236, 1, -1);
    for (int i = 0; i < 8; i++) check_eq("flip_order", 32'(obs_pix[256 + i]), 32'(seq_b[i]));
    check_eq("flip_rom_line", 32'(obs_rom[251]), 32'({8'h10, 3'd3}));
    for (int i = 256; i < 264; i++) check_eq("drain_ce_b", 32'(obs_ce[i]), 32'hF);

    for (int n = 0; n < 5; n++) begin
      flip = 1'($urandom);
      run_line(int'($urandom_range(0, 239)), 2, -1);
    end

    run_line(240, 2, -1);
    run_line(int'($urandom_range(0, 239)), 0, 100);
    for (int i = 101; i < 112; i++) check_eq("rst_zero", 32'(obs_pix[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
